// File: rtl/i2s_fmt_detect.sv
// i2s_fmt_detect
//   Measures ASCLK_i (BCK) cycles per ALRCLK_i frame, classifies each frame
//   against NUM_FMT inclusive count windows and locks onto a format with
//   hysteresis: LOCK_FRAMES consecutive matching frames to lock, LOCK_FRAMES
//   consecutive non-matching frames to release. fmt_sel_o steers the source
//   mux ahead of the FIR/ASRC path.
//
//   Optional feature macro: I2S_FMT_MUTE_EN
//     defined   : mute_o held for MUTE_FRAMES LRCLK rises after entering lock
//     undefined : mute_o is simply the registered inverse of fmt_valid_o
//
// Ports
//   ASCLK_i      in   I2S bit clock, all logic on the rising edge
//   nARST        in   asynchronous active-low reset
//   ALRCLK_i     in   I2S word clock, sampled on ASCLK_i
//   fmt_sel_o    out  locked format index (changes only on entering lock)
//   fmt_valid_o  out  1 while locked
//   frame_len_o  out  last measured frame length in BCKs minus one
//   frame_stb_o  out  one-cycle pulse per LRCLK rise
//   mute_o       out  downstream mute request

module i2s_fmt_detect #(
    parameter int unsigned CTR_W                     = 9,
    parameter int unsigned NUM_FMT                   = 2,
    parameter logic [NUM_FMT*CTR_W-1:0] FMT_MIN      = {9'd31, 9'd191},
    parameter logic [NUM_FMT*CTR_W-1:0] FMT_MAX      = {9'd31, 9'd209},
    parameter int unsigned DEF_SEL                   = 0,
    parameter int unsigned LOCK_FRAMES               = 3,
    parameter int unsigned MUTE_FRAMES               = 8,
    localparam int unsigned SEL_W = (NUM_FMT > 1) ? $clog2(NUM_FMT) : 1
) (
    input  logic             ASCLK_i,
    input  logic             nARST,
    input  logic             ALRCLK_i,
    output logic [SEL_W-1:0] fmt_sel_o,
    output logic             fmt_valid_o,
    output logic [CTR_W-1:0] frame_len_o,
    output logic             frame_stb_o,
    output logic             mute_o
);

    localparam int unsigned RUN_W = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [RUN_W-1:0] LOCK_CNT = RUN_W'(LOCK_FRAMES);
    localparam logic [CTR_W-1:0] CNT_MAX  = {CTR_W{1'b1}};

`ifdef I2S_FMT_MUTE_EN
    localparam int unsigned HOLD_W = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
`endif

    typedef enum logic [1:0] {
        StUnlock,
        StCand,
        StLock
    } state_e;

    logic [CTR_W-1:0] r_cnt;
    logic             r_lr_prev;
    logic [CTR_W-1:0] r_len;
    logic             r_stb;

    state_e           r_state;
    logic             r_first;
    logic [SEL_W-1:0] r_cand;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] r_miss;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic             r_mute;
`ifdef I2S_FMT_MUTE_EN
    logic [HOLD_W-1:0] r_hold;
`endif

    logic             w_rise;
    logic             w_timeout;
    logic             w_hit;
    logic [SEL_W-1:0] w_idx;
    logic             w_same;
    logic             w_drop;

    assign w_rise    = ~r_lr_prev & ALRCLK_i;
    // Saturated counter means no LRCLK edge for a full counter range.
    assign w_timeout = (r_cnt == CNT_MAX);

    // Lowest-index window containing the count wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int unsigned i = 0; i < NUM_FMT; i++) begin
            if (!w_hit && (r_cnt >= FMT_MIN[i*CTR_W +: CTR_W]) &&
                (r_cnt <= FMT_MAX[i*CTR_W +: CTR_W])) begin
                w_hit = 1'b1;
                w_idx = SEL_W'(i);
            end
        end
    end

    assign w_same = w_hit && (w_idx == r_sel);
    assign w_drop = !w_same && ((r_miss + 1'b1) == LOCK_CNT);

    // Frame length measurement.
    always_ff @(posedge ASCLK_i or negedge nARST) begin
        if (!nARST) begin
            r_cnt     <= '0;
            r_lr_prev <= 1'b0;
            r_len     <= '0;
            r_stb     <= 1'b0;
        end else begin
            r_lr_prev <= ALRCLK_i;
            r_stb     <= w_rise;
            if (w_rise) begin
                r_len <= r_cnt;
                r_cnt <= '0;
            end else if (!w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Lock FSM, evaluated once per LRCLK rise plus the timeout path.
    always_ff @(posedge ASCLK_i or negedge nARST) begin
        if (!nARST) begin
            r_state <= StUnlock;
            r_first <= 1'b1;
            r_cand  <= '0;
            r_run   <= '0;
            r_miss  <= '0;
            r_sel   <= SEL_W'(DEF_SEL);
            r_valid <= 1'b0;
            r_mute  <= 1'b1;
`ifdef I2S_FMT_MUTE_EN
            r_hold  <= '0;
`endif
        end else if (w_rise && (r_first || w_timeout)) begin
            // Partial or timed-out frame: only re-arm classification.
            r_first <= 1'b0;
            if (w_timeout) begin
                r_state <= StUnlock;
                r_valid <= 1'b0;
                r_mute  <= 1'b1;
`ifdef I2S_FMT_MUTE_EN
                r_hold  <= '0;
`endif
            end
        end else if (w_rise) begin
            case (r_state)
                StUnlock: begin
                    if (w_hit) begin
                        r_cand <= w_idx;
                        r_run  <= RUN_W'(1);
                        if (LOCK_FRAMES == 1) begin
                            r_state <= StLock;
                            r_sel   <= w_idx;
                            r_valid <= 1'b1;
                            r_miss  <= '0;
`ifdef I2S_FMT_MUTE_EN
                            r_hold  <= HOLD_W'(MUTE_FRAMES);
                            r_mute  <= (MUTE_FRAMES != 0);
`else
                            r_mute  <= 1'b0;
`endif
                        end else begin
                            r_state <= StCand;
                        end
                    end
                end
                StCand: begin
                    if (!w_hit) begin
                        r_state <= StUnlock;
                    end else if (w_idx == r_cand) begin
                        if ((r_run + 1'b1) == LOCK_CNT) begin
                            r_state <= StLock;
                            r_sel   <= r_cand;
                            r_valid <= 1'b1;
                            r_miss  <= '0;
`ifdef I2S_FMT_MUTE_EN
                            r_hold  <= HOLD_W'(MUTE_FRAMES);
                            r_mute  <= (MUTE_FRAMES != 0);
`else
                            r_mute  <= 1'b0;
`endif
                        end else begin
                            r_run <= r_run + 1'b1;
                        end
                    end else begin
                        r_cand <= w_idx;
                        r_run  <= RUN_W'(1);
                    end
                end
                StLock: begin
                    if (w_drop) begin
                        r_state <= StUnlock;
                        r_valid <= 1'b0;
                        r_mute  <= 1'b1;
`ifdef I2S_FMT_MUTE_EN
                        r_hold  <= '0;
`endif
                    end else begin
                        r_miss <= w_same ? '0 : (r_miss + 1'b1);
`ifdef I2S_FMT_MUTE_EN
                        if (r_hold != '0) begin
                            r_hold <= r_hold - 1'b1;
                        end
                        r_mute <= (r_hold > HOLD_W'(1));
`endif
                    end
                end
                default: begin
                    r_state <= StUnlock;
                    r_valid <= 1'b0;
                    r_mute  <= 1'b1;
                end
            endcase
        end else if (w_timeout) begin
            r_first <= 1'b1;
            r_state <= StUnlock;
            r_valid <= 1'b0;
            r_mute  <= 1'b1;
`ifdef I2S_FMT_MUTE_EN
            r_hold  <= '0;
`endif
        end
    end

    assign fmt_sel_o   = r_sel;
    assign fmt_valid_o = r_valid;
    assign frame_len_o = r_len;
    assign frame_stb_o = r_stb;
    assign mute_o      = r_mute;

endmodule

// File: tb/tb_i2s_fmt_detect.sv
// Self-checking bench for i2s_fmt_detect (default parameters).
// Directed scenarios check against hand-derived constants; the random
// scenario checks every cycle against a frame-level reference model.

module tb_i2s_fmt_detect;

    localparam int MAXC = 511;
    localparam int L    = 3;
    localparam int MUTE = 8;

    logic       ASCLK_i  = 1'b0;
    logic       nARST    = 1'b0;
    logic       ALRCLK_i = 1'b0;
    logic [0:0] fmt_sel_o;
    logic       fmt_valid_o;
    logic [8:0] frame_len_o;
    logic       frame_stb_o;
    logic       mute_o;

    int checks = 0;
    int errors = 0;

    i2s_fmt_detect dut (
        .ASCLK_i    (ASCLK_i),
        .nARST      (nARST),
        .ALRCLK_i   (ALRCLK_i),
        .fmt_sel_o  (fmt_sel_o),
        .fmt_valid_o(fmt_valid_o),
        .frame_len_o(frame_len_o),
        .frame_stb_o(frame_stb_o),
        .mute_o     (mute_o)
    );

    always #5 ASCLK_i = ~ASCLK_i;

    // Reference model state
    int m_cnt, m_prev, m_first, m_valid, m_sel, m_len, m_stb, m_hold;
    int hist[$];

    function automatic int fmt_of(input int n);
        if (n >= 191 && n <= 209) return 0;
        if (n == 31) return 1;
        return -1;
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_prev = 0; m_first = 1; m_valid = 0;
        m_sel = 0; m_len = 0; m_stb = 0; m_hold = 0;
        hist.delete();
    endfunction

    function automatic void model_unlock();
        m_valid = 0;
        m_hold  = 0;
        hist.delete();
    endfunction

    function automatic int model_mute();
`ifdef I2S_FMT_MUTE_EN
        return (m_valid == 0 || m_hold > 0) ? 1 : 0;
`else
        return (m_valid == 0) ? 1 : 0;
`endif
    endfunction

    // One classified frame: lock when the last L frames name the same format,
    // release when the last L frames since locking all differ from it.
    function automatic void model_frame(input int n);
        int f;
        int agree;
        int misses;
        f = fmt_of(n);
        hist.push_back(f);
        if (hist.size() > L) void'(hist.pop_front());
        if (m_valid == 0) begin
            agree = 0;
            if (hist.size() == L && f >= 0) begin
                agree = 1;
                foreach (hist[k]) if (hist[k] != f) agree = 0;
            end
            if (agree != 0) begin
                m_valid = 1;
                m_sel   = f;
                m_hold  = MUTE;
                hist.delete();
            end
        end else begin
            if (m_hold > 0) m_hold--;
            misses = 0;
            for (int k = hist.size() - 1; k >= 0; k--) begin
                if (hist[k] == m_sel) break;
                misses++;
            end
            if (misses >= L) model_unlock();
        end
    endfunction

    function automatic void model_edge(input int lr);
        int rise;
        rise   = (lr != 0 && m_prev == 0) ? 1 : 0;
        m_prev = lr;
        m_stb  = rise;
        if (rise != 0) begin
            m_len = m_cnt;
            if (m_first != 0 || m_cnt == MAXC) begin
                m_first = 0;
                if (m_cnt == MAXC) model_unlock();
            end else begin
                model_frame(m_cnt);
            end
            m_cnt = 0;
        end else if (m_cnt == MAXC) begin
            m_first = 1;
            model_unlock();
        end else begin
            m_cnt++;
        end
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input logic lr);
        ALRCLK_i = lr;
        @(posedge ASCLK_i);
        if (nARST) model_edge(int'(lr));
        @(negedge ASCLK_i);
    endtask

    // Remaining ticks of a frame whose rise tick was already driven.
    task automatic frame_rest(input int n, input int h);
        for (int i = 1; i < n; i++) tick(i < h);
    endtask

    task automatic do_reset();
        nARST = 1'b0;
        model_reset();
        tick(ALRCLK_i);
        tick(ALRCLK_i);
        nARST = 1'b1;
    endtask

    task automatic test_reset();
        nARST    = 1'b0;
        ALRCLK_i = 1'b0;
        model_reset();
        @(negedge ASCLK_i);
        checks += 5;
        if (fmt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fmt_valid_o); end
        if (fmt_sel_o !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", fmt_sel_o); end
        if (frame_len_o !== 9'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", frame_len_o); end
        if (frame_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", frame_stb_o); end
        if (mute_o !== 1'b1) begin errors++; $display("FAIL reset_mute: got %b want 1", mute_o); end
        tick(1'b0);
        nARST = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_lock_32();
        logic ev, es, em;
        for (int f = 1; f <= 6; f++) begin
            tick(1'b1);
            ev = (f >= 4);
            es = (f >= 4);
`ifdef I2S_FMT_MUTE_EN
            em = 1'b1;
`else
            em = ~ev;
`endif
            checks += 4;
            if (frame_stb_o !== 1'b1) begin errors++; $display("FAIL lock32_stb f%0d: got %b want 1", f, frame_stb_o); end
            if (fmt_valid_o !== ev) begin errors++; $display("FAIL lock32_valid f%0d: got %b want %b", f, fmt_valid_o, ev); end
            if (fmt_sel_o !== es) begin errors++; $display("FAIL lock32_sel f%0d: got %b want %b", f, fmt_sel_o, es); end
            if (mute_o !== em) begin errors++; $display("FAIL lock32_mute f%0d: got %b want %b", f, mute_o, em); end
            if (f >= 2) begin
                checks++;
                if (frame_len_o !== 9'd31) begin errors++; $display("FAIL lock32_len f%0d: got %0d want 31", f, frame_len_o); end
            end
            frame_rest(32, 16);
            checks++;
            if (frame_stb_o !== 1'b0) begin errors++; $display("FAIL lock32_stb_low f%0d: got %b want 0", f, frame_stb_o); end
        end
    endtask

    task automatic test_switch_200();
        logic ev, es;
        for (int f = 1; f <= 7; f++) begin
            tick(1'b1);
            ev = (f <= 3 || f == 7);
            es = (f != 7);
            checks += 3;
            if (fmt_valid_o !== ev) begin errors++; $display("FAIL sw200_valid f%0d: got %b want %b", f, fmt_valid_o, ev); end
            if (fmt_sel_o !== es) begin errors++; $display("FAIL sw200_sel f%0d: got %b want %b", f, fmt_sel_o, es); end
            if (frame_len_o !== ((f == 1) ? 9'd31 : 9'd199)) begin
                errors++; $display("FAIL sw200_len f%0d: got %0d", f, frame_len_o);
            end
            frame_rest(200, 100);
        end
    endtask

    task automatic test_timeout();
        for (int f = 1; f <= 7; f++) begin
            tick(1'b1);
            frame_rest(32, 16);
        end
        checks += 2;
        if (fmt_valid_o !== 1'b1) begin errors++; $display("FAIL to_prelock_valid: got %b want 1", fmt_valid_o); end
        if (fmt_sel_o !== 1'b1) begin errors++; $display("FAIL to_prelock_sel: got %b want 1", fmt_sel_o); end
        for (int i = 0; i < 470; i++) tick(1'b0);
        checks++;
        if (fmt_valid_o !== 1'b1) begin errors++; $display("FAIL to_early_valid: got %b want 1", fmt_valid_o); end
        for (int i = 0; i < 20; i++) tick(1'b0);
        checks += 2;
        if (fmt_valid_o !== 1'b0) begin errors++; $display("FAIL to_valid: got %b want 0", fmt_valid_o); end
        if (fmt_sel_o !== 1'b1) begin errors++; $display("FAIL to_sel_held: got %b want 1", fmt_sel_o); end
        for (int i = 0; i < 30; i++) tick(1'b0);
        for (int f = 1; f <= 5; f++) begin
            tick(1'b1);
            if (f == 1) begin
                checks++;
                if (frame_len_o !== 9'd511) begin errors++; $display("FAIL to_len_sat: got %0d want 511", frame_len_o); end
            end
            checks++;
            if (fmt_valid_o !== (f >= 4)) begin
                errors++; $display("FAIL to_relock_valid f%0d: got %b want %b", f, fmt_valid_o, (f >= 4));
            end
            frame_rest(32, 16);
        end
    endtask

    task automatic test_reset_mid_cand();
        for (int f = 1; f <= 6; f++) begin
            tick(1'b1);
            frame_rest((f == 6) ? 10 : 200, 100);
        end
        checks += 2;
        if (fmt_valid_o !== 1'b0) begin errors++; $display("FAIL rmc_pre_valid: got %b want 0", fmt_valid_o); end
        if (fmt_sel_o !== 1'b1) begin errors++; $display("FAIL rmc_pre_sel: got %b want 1", fmt_sel_o); end
        ALRCLK_i = 1'b0;
        nARST    = 1'b0;
        model_reset();
        #1;
        checks += 4;
        if (fmt_sel_o !== 1'b0) begin errors++; $display("FAIL rmc_sel: got %b want 0", fmt_sel_o); end
        if (frame_len_o !== 9'd0) begin errors++; $display("FAIL rmc_len: got %0d want 0", frame_len_o); end
        if (mute_o !== 1'b1) begin errors++; $display("FAIL rmc_mute: got %b want 1", mute_o); end
        if (fmt_valid_o !== 1'b0) begin errors++; $display("FAIL rmc_valid: got %b want 0", fmt_valid_o); end
        @(negedge ASCLK_i);
        tick(1'b0);
        nARST = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            tick(1'b1);
            checks += 2;
            if (fmt_valid_o !== (f == 4)) begin
                errors++; $display("FAIL rmc_relock_valid f%0d: got %b want %b", f, fmt_valid_o, (f == 4));
            end
            if (fmt_sel_o !== (f == 4)) begin
                errors++; $display("FAIL rmc_relock_sel f%0d: got %b want %b", f, fmt_sel_o, (f == 4));
            end
            frame_rest(32, 16);
        end
    endtask

    task automatic test_no_lock();
        int n;
        do_reset();
        for (int f = 1; f <= 16; f++) begin
            n = (f <= 6) ? 100 : ((f % 2 == 0) ? 32 : 200);
            tick(1'b1);
            checks += 2;
            if (fmt_valid_o !== 1'b0) begin errors++; $display("FAIL nolock_valid f%0d: got %b want 0", f, fmt_valid_o); end
            if (fmt_sel_o !== 1'b0) begin errors++; $display("FAIL nolock_sel f%0d: got %b want 0", f, fmt_sel_o); end
            if (f >= 2 && f <= 6) begin
                checks++;
                if (frame_len_o !== 9'd99) begin errors++; $display("FAIL nolock_len f%0d: got %0d want 99", f, frame_len_o); end
            end
            frame_rest(n, n / 2);
        end
    endtask

    task automatic test_random();
        int n, h, kind, rst_at;
        logic lr;
        do_reset();
        for (int f = 0; f < 140; f++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 3)      n = 32;
            else if (kind <= 6) n = int'($urandom_range(192, 210));
            else if (kind == 7) n = 100;
            else if (kind == 8) n = int'($urandom_range(2, 300));
            else                n = int'($urandom_range(530, 600));
            h      = int'($urandom_range(1, n - 1));
            rst_at = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, n - 1)) : -1;
            for (int i = 0; i < n; i++) begin
                lr = (i < h);
                if (i == rst_at) begin
                    nARST = 1'b0;
                    model_reset();
                    tick(lr);
                    nARST = 1'b1;
                end
                tick(lr);
                checks += 5;
                if (fmt_valid_o !== (m_valid != 0)) begin
                    errors++; $display("FAIL rnd_valid f%0d t%0d: got %b want %0d", f, i, fmt_valid_o, m_valid);
                end
                if (fmt_sel_o !== m_sel[0]) begin
                    errors++; $display("FAIL rnd_sel f%0d t%0d: got %b want %0d", f, i, fmt_sel_o, m_sel);
                end
                if (frame_len_o !== m_len[8:0]) begin
                    errors++; $display("FAIL rnd_len f%0d t%0d: got %0d want %0d", f, i, frame_len_o, m_len);
                end
                if (frame_stb_o !== (m_stb != 0)) begin
                    errors++; $display("FAIL rnd_stb f%0d t%0d: got %b want %0d", f, i, frame_stb_o, m_stb);
                end
                if (mute_o !== (model_mute() != 0)) begin
                    errors++; $display("FAIL rnd_mute f%0d t%0d: got %b want %0d", f, i, mute_o, model_mute());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_32();
        test_switch_200();
        test_timeout();
        test_reset_mid_cand();
        test_no_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
